button_step_debouncer: RTL and testbench
========================================

BUTTON_STEP_DEBOUNCER -- requirements
Module: button_step_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter COUNT_W, default 16, SHALL set the width of step_count.
REQ-003 clk  input  1  SHALL be the free-running board clock (pin E3, 100 MHz), the only clock in the block.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low (rst=0 sampled at a clk rising edge resets).
REQ-005 btn_raw  input  1  SHALL be the raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 step_clk  output  1  SHALL be the debounced button level, registered, used directly as the single-step clock of the pipelined core.
REQ-007 press_pulse  output  1  SHALL be a one-cycle strobe on each accepted press.
REQ-008 release_pulse  output  1  SHALL be a one-cycle strobe on each accepted release.
REQ-009 step_count  output  COUNT_W  SHALL count accepted presses, for display on the seven-segment driver.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer; the second flop output (btn_s) is the only value the FSM reads.
REQ-011 FSM states SHALL be IDLE (level 0), DB_PRESS, PRESSED (level 1), DB_RELEASE; a 24-bit counter cnt SHALL time the DB_* states.
REQ-012 IDLE: btn_s=1 -> DB_PRESS with cnt=0; otherwise stay.
REQ-013 DB_PRESS: btn_s=0 -> IDLE, no pulse; btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-014 PRESSED: btn_s=0 -> DB_RELEASE with cnt=0; otherwise stay.
REQ-015 DB_RELEASE: btn_s=1 -> PRESSED, no pulse; btn_s=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-016 step_clk SHALL be 1 exactly while state is PRESSED or DB_RELEASE, registered (no combinational path from btn_raw or btn_s).
REQ-017 press_pulse SHALL be 1 for exactly the one cycle in which the state first becomes PRESSED from DB_PRESS; release_pulse likewise for IDLE entered from DB_RELEASE.
REQ-018 Latency: for btn_raw stable from edge E0 (first edge sampling 1), step_clk and press_pulse SHALL become 1 after edge E0+DEBOUNCE_CYCLES+2; release is symmetric.
REQ-019 step_count SHALL increment by 1 in the same edge that asserts press_pulse, modulo 2^COUNT_W (all-ones wraps to 0).
REQ-020 A bounce at the terminal-count cycle (btn_s opposite at cnt=DEBOUNCE_CYCLES-1) SHALL abort: no level change, no pulse, no count.
REQ-021 Each debounce attempt SHALL restart cnt from 0; partial counts SHALL never carry over.
REQ-022 press_pulse and release_pulse SHALL never be 1 in the same cycle; between two press_pulses exactly one release_pulse SHALL occur.

Reset
REQ-023 rst=0 at any edge, in any state, SHALL force: synchronizer flops 0, state IDLE, cnt 0, step_clk 0, press_pulse 0, release_pulse 0, step_count 0.
REQ-024 Reset SHALL dominate all other events in the same edge, including a terminal-count transition.
REQ-025 If btn_raw is held 1 across reset release, a full debounce SHALL follow and the press SHALL be counted (step_count=1).

Verification (DEBOUNCE_CYCLES=4, COUNT_W=4)
REQ-026 Clean press: btn_raw 0->1 held from edge E0 -> step_clk=1 and press_pulse=1 after E6, press_pulse=0 after E7, step_count=1.
REQ-027 Bounce: btn_raw 1 for 3 cycles, 0 for 1, then 1 held -> no pulse before the final debounce; exactly one press_pulse; step_count=1.
REQ-028 Terminal-count glitch: btn_s drops to 0 exactly when cnt=3 in DB_PRESS -> return to IDLE, step_clk stays 0, step_count unchanged.
REQ-029 Wrap: 16 clean press/release cycles from reset -> step_count 0xF after 15th, 0x0 after 16th; 16 release_pulses total.
REQ-030 Reset mid-operation: rst=0 for one edge while in PRESSED with step_count=5 -> all outputs 0 next cycle; btn_raw still 1 -> press re-accepted after DEBOUNCE_CYCLES+3 edges, step_count=1.
REQ-031 Release: from PRESSED, btn_raw 1->0 held -> release_pulse single cycle, step_clk=0 after same edge, step_count unchanged.

Source files
------------

// File: rtl/button_step_debouncer.sv
// -----------------------------------------------------------------------------
// button_step_debouncer
//
// Turns a raw, bouncing push-button into a clean level that clocks a pipelined
// core one step at a time. The button is synchronized with two flops, then a
// four-state FSM only accepts a level change after DEBOUNCE_CYCLES consecutive
// samples at the new level. Any opposite sample during the count aborts the
// attempt. The next attempt starts counting from zero again.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a change
//                     (legal range 2 .. 2^24-1; default is 10 ms at 100 MHz)
//   COUNT_W         : width of step_count
//
// Ports
//   clk           in   free-running board clock, the only clock here
//   rst           in   synchronous reset, active low
//   btn_raw       in   raw asynchronous button level (1 = pressed)
//   step_clk      out  debounced button level, registered
//   press_pulse   out  one-cycle strobe on each accepted press
//   release_pulse out  one-cycle strobe on each accepted release
//   step_count    out  number of accepted presses, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module button_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  output logic               step_clk,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic [COUNT_W-1:0] step_count
);

  // The count runs 0 .. DEBOUNCE_CYCLES-1. Reaching the terminal value with
  // the level still held means DEBOUNCE_CYCLES stable samples have been seen.
  localparam logic [23:0] TERMINAL = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,  // accepted level 0
    DB_PRESS   = 2'd1,  // level 1 seen, timing the press
    PRESSED    = 2'd2,  // accepted level 1
    DB_RELEASE = 2'd3   // level 0 seen, timing the release
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Only btn_s, the second flop, reaches the FSM.
  // ---------------------------------------------------------------------------
  logic sync_meta_reg;
  logic btn_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta_reg <= 1'b0;
      btn_s         <= 1'b0;
    end else begin
      sync_meta_reg <= btn_raw;
      btn_s         <= sync_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and debounce counter
  // ---------------------------------------------------------------------------
  state_t       state_reg;
  state_t       state_next;
  logic [23:0]  cnt_reg;
  logic [23:0]  cnt_next;

  logic               step_clk_reg;
  logic               step_clk_next;
  logic               press_pulse_reg;
  logic               press_pulse_next;
  logic               release_pulse_reg;
  logic               release_pulse_next;
  logic [COUNT_W-1:0] step_count_reg;
  logic [COUNT_W-1:0] step_count_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      step_clk_reg      <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      step_count_reg    <= '0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      step_clk_reg      <= step_clk_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
      step_count_reg    <= step_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The pulses are produced only on the two transitions that
  // complete a debounce. An abort goes back to the previous stable state and
  // does not produce a pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    press_pulse_next   = 1'b0;
    release_pulse_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = DB_PRESS;
          cnt_next   = '0;
        end
      end

      DB_PRESS: begin
        if (!btn_s) begin
          // A bounce, including one at the terminal count, cancels the press.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == TERMINAL) begin
          state_next       = PRESSED;
          cnt_next         = '0;
          press_pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end

      DB_RELEASE: begin
        if (btn_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == TERMINAL) begin
          state_next         = IDLE;
          cnt_next           = '0;
          release_pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The level is decoded from the next state and registered. This lets
  // step_clk rise on the same edge as press_pulse. It also keeps the level
  // glitch-free, because no combinational path runs from the button to the
  // core clock.
  always_comb begin
    step_clk_next = (state_next == PRESSED) || (state_next == DB_RELEASE);
  end

  // The press counter wraps naturally at 2^COUNT_W.
  always_comb begin
    step_count_next = step_count_reg;
    if (press_pulse_next) begin
      step_count_next = step_count_reg + COUNT_W'(1);
    end
  end

  assign step_clk      = step_clk_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign step_count    = step_count_reg;

endmodule

// File: tb/tb_button_step_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_step_debouncer
//
// Directed bench for button_step_debouncer with DEBOUNCE_CYCLES=4, COUNT_W=4.
// Edge E0 is the first clock edge that samples a new btn_raw level. Outputs
// are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_step_debouncer;
  localparam int DC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_raw = 1'b0;
  logic          step_clk;
  logic          press_pulse;
  logic          release_pulse;
  logic [CW-1:0] step_count;

  int checks = 0;
  int passed = 0;

  // Pulse monitor: the counts only increase, and tests compare snapshots.
  int press_seen   = 0;
  int release_seen = 0;
  int both_seen    = 0;

  button_step_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .COUNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .step_clk     (step_clk),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse)   press_seen++;
    if (release_pulse) release_seen++;
    if (press_pulse && release_pulse) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst     = 1'b0;
    btn_raw = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Press and wait for the accepted press, with a bounded wait.
  task automatic do_press();
    bit got;
    got     = 1'b0;
    btn_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (press_pulse) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL press_timeout: press_pulse=0 after 20 cycles, want 1");
    end
    tick();
  endtask

  task automatic do_release();
    bit got;
    got     = 1'b0;
    btn_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (release_pulse) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL release_timeout: release_pulse=0 after 20 cycles, want 1");
    end
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    btn_raw = 1'b1;
    tick();
    tick();
    checks++;
    if ({step_clk, press_pulse, release_pulse, step_count} !== {3'b000, 4'h0})
      $display("FAIL reset_outputs: got step_clk=%b press=%b release=%b count=%h want 0 0 0 0",
               step_clk, press_pulse, release_pulse, step_count);
    else begin passed++; $display("pass reset_outputs"); end
    btn_raw = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
  endtask

  // Clean press from IDLE. The level and the pulse appear after E6.
  task automatic test_clean_press(input logic [CW-1:0] exp_count);
    btn_raw = 1'b1;
    tick();                              // E0
    for (int i = 1; i <= 5; i++) tick(); // E1..E5
    checks++;
    if ({step_clk, press_pulse} !== 2'b00)
      $display("FAIL press_early: got step_clk=%b press=%b after E5 want 0 0", step_clk, press_pulse);
    else begin passed++; $display("pass press_early"); end
    tick();                              // E6
    checks++;
    if ({step_clk, press_pulse, step_count} !== {2'b11, exp_count})
      $display("FAIL press_e6: got step_clk=%b press=%b count=%h want 1 1 %h",
               step_clk, press_pulse, step_count, exp_count);
    else begin passed++; $display("pass press_e6"); end
    tick();                              // E7
    checks++;
    if ({step_clk, press_pulse, step_count} !== {2'b10, exp_count})
      $display("FAIL press_e7: got step_clk=%b press=%b count=%h want 1 0 %h",
               step_clk, press_pulse, step_count, exp_count);
    else begin passed++; $display("pass press_e7"); end
  endtask

  // Release from PRESSED. This case mirrors the press.
  task automatic test_release(input logic [CW-1:0] exp_count);
    btn_raw = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) tick();
    checks++;
    if ({step_clk, release_pulse} !== 2'b10)
      $display("FAIL release_early: got step_clk=%b release=%b want 1 0", step_clk, release_pulse);
    else begin passed++; $display("pass release_early"); end
    tick();
    checks++;
    if ({step_clk, release_pulse, step_count} !== {2'b01, exp_count})
      $display("FAIL release_e6: got step_clk=%b release=%b count=%h want 0 1 %h",
               step_clk, release_pulse, step_count, exp_count);
    else begin passed++; $display("pass release_e6"); end
    tick();
    checks++;
    if ({step_clk, release_pulse} !== 2'b00)
      $display("FAIL release_e7: got step_clk=%b release=%b want 0 0", step_clk, release_pulse);
    else begin passed++; $display("pass release_e7"); end
  endtask

  // btn_raw is 1 at E0..E2 and 0 at E3, then held at 1. The debounce starts
  // again at E6 and completes at E10.
  task automatic test_bounce();
    int p0;
    apply_reset();
    p0      = press_seen;
    btn_raw = 1'b1;
    tick(); tick(); tick();              // E0..E2
    btn_raw = 1'b0;
    tick();                              // E3
    btn_raw = 1'b1;
    for (int i = 4; i <= 9; i++) tick(); // E4..E9
    checks++;
    if (press_seen != p0 || step_clk !== 1'b0)
      $display("FAIL bounce_early: got presses=%0d step_clk=%b want 0 0", press_seen - p0, step_clk);
    else begin passed++; $display("pass bounce_early"); end
    tick();                              // E10
    checks++;
    if ({step_clk, press_pulse, step_count} !== {2'b11, 4'h1})
      $display("FAIL bounce_e10: got step_clk=%b press=%b count=%h want 1 1 1",
               step_clk, press_pulse, step_count);
    else begin passed++; $display("pass bounce_e10"); end
    tick(); tick(); tick();
    checks++;
    if (press_seen - p0 != 1)
      $display("FAIL bounce_once: got %0d presses want 1", press_seen - p0);
    else begin passed++; $display("pass bounce_once"); end
    do_release();
  endtask

  // btn_raw drops at E4. The FSM sees btn_s=0 at E6, while cnt is at terminal.
  task automatic test_terminal_glitch();
    int p0;
    apply_reset();
    p0      = press_seen;
    btn_raw = 1'b1;
    for (int i = 0; i <= 3; i++) tick(); // E0..E3
    btn_raw = 1'b0;
    for (int i = 4; i <= 9; i++) tick(); // E4..E9
    checks++;
    if (step_clk !== 1'b0 || press_seen != p0 || step_count !== 4'h0)
      $display("FAIL glitch_abort: got step_clk=%b presses=%0d count=%h want 0 0 0",
               step_clk, press_seen - p0, step_count);
    else begin passed++; $display("pass glitch_abort"); end
    // The FSM must be back in IDLE, so a fresh press takes the full latency.
    test_clean_press(4'h1);
    do_release();
  endtask

  // Reset wins over a terminal-count transition at E6.
  task automatic test_reset_dominates();
    apply_reset();
    btn_raw = 1'b1;
    for (int i = 0; i <= 5; i++) tick(); // E0..E5
    rst = 1'b0;
    tick();                              // E6 with reset
    checks++;
    if ({step_clk, press_pulse, step_count} !== {2'b00, 4'h0})
      $display("FAIL reset_dominates: got step_clk=%b press=%b count=%h want 0 0 0",
               step_clk, press_pulse, step_count);
    else begin passed++; $display("pass reset_dominates"); end
    rst     = 1'b1;
    btn_raw = 1'b0;
    do_press();   // btn_raw is released to 0 by apply_reset below
    apply_reset();
  endtask

  task automatic test_wrap();
    int p0;
    int r0;
    apply_reset();
    p0 = press_seen;
    r0 = release_seen;
    for (int n = 1; n <= 16; n++) begin
      do_press();
      if (n == 15) begin
        checks++;
        if (step_count !== 4'hF)
          $display("FAIL wrap_15: got count=%h want f", step_count);
        else begin passed++; $display("pass wrap_15"); end
      end
      if (n == 16) begin
        checks++;
        if (step_count !== 4'h0)
          $display("FAIL wrap_16: got count=%h want 0", step_count);
        else begin passed++; $display("pass wrap_16"); end
      end
      do_release();
    end
    checks++;
    if (release_seen - r0 != 16 || press_seen - p0 != 16)
      $display("FAIL wrap_pulses: got presses=%0d releases=%0d want 16 16",
               press_seen - p0, release_seen - r0);
    else begin passed++; $display("pass wrap_pulses"); end
  endtask

  // Reset for one edge while PRESSED with count 5. The button is still held,
  // so the press is accepted again DC+3 edges after the reset edge.
  task automatic test_reset_mid();
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      do_press();
      do_release();
    end
    do_press();
    checks++;
    if ({step_clk, step_count} !== {1'b1, 4'h5})
      $display("FAIL mid_setup: got step_clk=%b count=%h want 1 5", step_clk, step_count);
    else begin passed++; $display("pass mid_setup"); end
    rst = 1'b0;
    tick();                              // R
    rst = 1'b1;
    checks++;
    if ({step_clk, press_pulse, release_pulse, step_count} !== {3'b000, 4'h0})
      $display("FAIL mid_reset: got step_clk=%b press=%b release=%b count=%h want 0 0 0 0",
               step_clk, press_pulse, release_pulse, step_count);
    else begin passed++; $display("pass mid_reset"); end
    for (int i = 1; i <= 6; i++) tick(); // R+1..R+6
    checks++;
    if ({step_clk, press_pulse} !== 2'b00)
      $display("FAIL mid_early: got step_clk=%b press=%b at R+6 want 0 0", step_clk, press_pulse);
    else begin passed++; $display("pass mid_early"); end
    tick();                              // R+7
    checks++;
    if ({step_clk, press_pulse, step_count} !== {2'b11, 4'h1})
      $display("FAIL mid_reaccept: got step_clk=%b press=%b count=%h want 1 1 1",
               step_clk, press_pulse, step_count);
    else begin passed++; $display("pass mid_reaccept"); end
    tick();
    test_release(4'h1);
  endtask

  task automatic test_pulse_exclusive();
    checks++;
    if (both_seen != 0)
      $display("FAIL pulse_exclusive: got %0d cycles with both pulses want 0", both_seen);
    else begin passed++; $display("pass pulse_exclusive"); end
  endtask

  initial begin
    test_reset();
    test_clean_press(4'h1);
    test_release(4'h1);
    test_bounce();
    test_terminal_glitch();
    test_reset_dominates();
    test_wrap();
    test_reset_mid();
    test_pulse_exclusive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
